uart_tx_arbiter: RTL and testbench

- Shares one uart_tx transmitter among NUM_REQ requesters (debug console, status reporter, etc.).
- Arbitration is round-robin at packet level. A granted requester keeps the transmitter until it has transferred a word flagged last.
- An optional stall timeout reclaims the grant from a requester that stops supplying data mid-packet.
- Sits directly upstream of uart_tx and drives its tx_data / tx_data_valid / tx_data_ready handshake.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rr_picker.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-level constants used by uart_tx and the
// arbiter's state encoding plus width helpers for its derived parameters.
package uart_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;
    localparam logic TX_STOP  = 1'b1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Stall counter width able to hold the timeout value itself.
    function automatic int stall_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping around to the lowest index when none is found above it.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               any,
    output logic [GRANT_W-1:0] winner
);

    logic [NUM_REQ-1:0] upper_s;
    logic [NUM_REQ-1:0] cand_s;
    logic [NUM_REQ-1:0] onehot_s;

    // Requests at or above the pointer take precedence; otherwise fall back to all.
    always_comb begin
        upper_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_s[i] = (GRANT_W'(i) >= rr_ptr);
        end
        if (|(req & upper_s)) begin
            cand_s = req & upper_s;
        end else begin
            cand_s = req;
        end
        onehot_s = cand_s & (~cand_s + NUM_REQ'(1));
    end

    // Encode the isolated lowest set bit into an index.
    always_comb begin
        any    = |req;
        winner = {GRANT_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            winner = winner | (GRANT_W'(i) & {GRANT_W{onehot_s[i]}});
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among NUM_REQ requesters,
// with an optional stall timeout that reclaims the grant mid-packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  WORD_LENGTH   = 8,
    parameter int  STALL_TIMEOUT = 1000000,
    localparam int GRANT_W       = grant_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [WORD_LENGTH-1:0]         tx_data,
    output logic                           tx_data_valid,
    input  logic                           tx_data_ready,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           busy,
    output logic                           abort
);

    localparam int                  STALL_W    = stall_width(STALL_TIMEOUT);
    localparam bit                  TIMEOUT_EN = (STALL_TIMEOUT != 0);
    localparam logic [STALL_W-1:0]  STALL_LAST = (STALL_TIMEOUT > 0) ?
                                                 STALL_W'(STALL_TIMEOUT - 1) : {STALL_W{1'b0}};
    localparam logic [STALL_W-1:0]  STALL_MAX  = {STALL_W{1'b1}};
    localparam logic [GRANT_W-1:0]  LAST_REQ   = GRANT_W'(NUM_REQ - 1);

    arb_state_t             state_r;
    arb_state_t             state_s;
    logic [GRANT_W-1:0]     rr_ptr_r;
    logic [GRANT_W-1:0]     grant_r;
    logic [STALL_W-1:0]     stall_cnt_r;
    logic                   abort_r;

    logic                   pick_any_s;
    logic [GRANT_W-1:0]     pick_winner_s;
    logic [GRANT_W-1:0]     next_ptr_s;
    logic [NUM_REQ-1:0]     grant_oh_s;
    logic                   sel_valid_s;
    logic                   sel_last_s;
    logic [WORD_LENGTH-1:0] sel_data_s;
    logic                   xfer_s;
    logic                   timeout_s;
    logic                   pkt_end_s;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_r),
        .any    (pick_any_s),
        .winner (pick_winner_s)
    );

    // Decode the grantee and mux its word, valid and last with an AND-OR tree.
    always_comb begin
        grant_oh_s  = {NUM_REQ{1'b0}};
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = {WORD_LENGTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh_s[i] = (grant_r == GRANT_W'(i));
            sel_valid_s   = sel_valid_s | (req_valid[i] & grant_oh_s[i]);
            sel_last_s    = sel_last_s  | (req_last[i]  & grant_oh_s[i]);
            sel_data_s    = sel_data_s  |
                            (req_data[i*WORD_LENGTH +: WORD_LENGTH] & {WORD_LENGTH{grant_oh_s[i]}});
        end
    end

    // Zero-latency pass-through of the grantee while sending; everything quiet in ARB.
    always_comb begin
        if (state_r == SEND) begin
            busy          = 1'b1;
            tx_data       = sel_data_s;
            tx_data_valid = sel_valid_s;
            req_ready     = grant_oh_s & {NUM_REQ{tx_data_ready}};
        end else begin
            busy          = 1'b0;
            tx_data       = {WORD_LENGTH{1'b0}};
            tx_data_valid = 1'b0;
            req_ready     = {NUM_REQ{1'b0}};
        end
    end

    // Packet termination: a transferred last word, or the stall limit reached with valid still low.
    always_comb begin
        xfer_s     = tx_data_valid & tx_data_ready;
        timeout_s  = TIMEOUT_EN & (state_r == SEND) & ~sel_valid_s & (stall_cnt_r == STALL_LAST);
        pkt_end_s  = (state_r == SEND) & ((xfer_s & sel_last_s) | timeout_s);
        if (grant_r == LAST_REQ) begin
            next_ptr_s = {GRANT_W{1'b0}};
        end else begin
            next_ptr_s = grant_r + GRANT_W'(1);
        end
    end

    // Next-state logic: ARB lasts one cycle when anyone requests, SEND runs to packet end.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB: begin
                if (pick_any_s) begin
                    state_s = SEND;
                end else begin
                    state_s = ARB;
                end
            end
            SEND: begin
                if (pkt_end_s) begin
                    state_s = ARB;
                end else begin
                    state_s = SEND;
                end
            end
            default: state_s = ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant capture on arbitration; pointer moves past the grantee when its packet ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r  <= {GRANT_W{1'b0}};
            rr_ptr_r <= {GRANT_W{1'b0}};
        end else if ((state_r == ARB) && pick_any_s) begin
            grant_r  <= pick_winner_s;
            rr_ptr_r <= rr_ptr_r;
        end else if (pkt_end_s) begin
            grant_r  <= grant_r;
            rr_ptr_r <= next_ptr_s;
        end else begin
            grant_r  <= grant_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Saturating stall counter and the one-cycle abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {STALL_W{1'b0}};
            abort_r     <= 1'b0;
        end else begin
            abort_r <= timeout_s;
            if ((state_r != SEND) || sel_valid_s || timeout_s) begin
                stall_cnt_r <= {STALL_W{1'b0}};
            end else if (stall_cnt_r != STALL_MAX) begin
                stall_cnt_r <= stall_cnt_r + STALL_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign grant_id = grant_r;
    assign abort    = abort_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: queue-driven requesters, a stub uart_tx
// and a transaction-level arbitration model; a second instance covers timeout=0.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int WL = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR*WL-1:0]  req_data;
    logic [NR-1:0]     req_valid, req_last, req_ready;
    logic [WL-1:0]     tx_data;
    logic              tx_data_valid, tx_data_ready;
    logic [1:0]        grant_id;
    logic              busy, abort;

    logic [NR*WL-1:0]  nt_req_data;
    logic [NR-1:0]     nt_req_valid, nt_req_last, nt_req_ready;
    logic [WL-1:0]     nt_tx_data;
    logic              nt_tx_data_valid, nt_tx_data_ready;
    logic [1:0]        nt_grant_id;
    logic              nt_busy, nt_abort;

    uart_tx_arbiter #(.NUM_REQ(NR), .WORD_LENGTH(WL), .STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .grant_id(grant_id), .busy(busy), .abort(abort)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .WORD_LENGTH(WL), .STALL_TIMEOUT(0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .req_data(nt_req_data), .req_valid(nt_req_valid),
        .req_last(nt_req_last), .req_ready(nt_req_ready), .tx_data(nt_tx_data),
        .tx_data_valid(nt_tx_data_valid), .tx_data_ready(nt_tx_data_ready),
        .grant_id(nt_grant_id), .busy(nt_busy), .abort(nt_abort)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } word_t;

    word_t q [NR][$];
    bit    pres [NR];
    bit    gap_loaded [NR];
    int    gap_left [NR];
    int    rdy_wait = 0;
    int    rdy_max  = 0;

    // Reference model: who owns the transmitter, where round-robin resumes,
    // and how long the owner has been silent.
    bit    m_send  = 1'b0;
    int    m_gid   = 0;
    int    m_ptr   = 0;
    int    m_run   = 0;
    bit    m_abort = 1'b0;
    int    grant_log [$];
    int    abort_seen = 0;

    task automatic add_word(input int r, input logic [7:0] d, input logic l, input int g);
        word_t w;
        w.data = d;
        w.last = l;
        w.gap  = g;
        q[r].push_back(w);
    endtask

    function automatic bit pending();
        for (int r = 0; r < NR; r++) begin
            if (q[r].size() != 0 || pres[r]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_drivers();
        for (int r = 0; r < NR; r++) begin
            q[r].delete();
            pres[r]       = 1'b0;
            gap_loaded[r] = 1'b0;
            gap_left[r]   = 0;
        end
        rdy_wait      = 0;
        req_valid     = {NR{1'b0}};
        req_last      = {NR{1'b0}};
        req_data      = {(NR*WL){1'b0}};
        tx_data_ready = 1'b0;
    endtask

    task automatic step();
        int  g;
        bit  found;
        @(posedge clk);
        #1;
        req_valid = {NR{1'b0}};
        req_last  = {NR{1'b0}};
        req_data  = {(NR*WL){1'b0}};
        for (int r = 0; r < NR; r++) begin
            if (!pres[r] && q[r].size() > 0) begin
                if (!gap_loaded[r]) begin
                    gap_left[r]   = q[r][0].gap;
                    gap_loaded[r] = 1'b1;
                end
                if (gap_left[r] == 0) pres[r] = 1'b1;
                else gap_left[r]--;
            end
            if (pres[r]) begin
                req_valid[r]           = 1'b1;
                req_last[r]            = q[r][0].last;
                req_data[r*WL +: WL]   = q[r][0].data;
            end
        end
        tx_data_ready = (rdy_wait == 0);
        if (rdy_wait > 0) rdy_wait--;

        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_send));
        chk("tx_data_valid", 32'(tx_data_valid), m_send ? 32'(req_valid[m_gid]) : 32'd0);
        chk("tx_data", 32'(tx_data), m_send ? 32'(req_data[m_gid*WL +: WL]) : 32'd0);
        chk("req_ready", 32'(req_ready), (m_send && tx_data_ready) ? (32'd1 << m_gid) : 32'd0);
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("abort", 32'(abort), 32'(m_abort));
        abort_seen += int'(abort);

        m_abort = 1'b0;
        if (!m_send) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!found && req_valid[(m_ptr + k) % NR]) begin
                    found = 1'b1;
                    m_gid = (m_ptr + k) % NR;
                end
            end
            if (found) begin
                m_send = 1'b1;
                m_run  = 0;
                grant_log.push_back(m_gid);
            end
        end else begin
            g = m_gid;
            if (req_valid[g] && tx_data_ready) begin
                void'(q[g].pop_front());
                pres[g]       = 1'b0;
                gap_loaded[g] = 1'b0;
                rdy_wait      = $urandom_range(rdy_max, 0);
                m_run         = 0;
                if (req_last[g]) begin
                    m_send = 1'b0;
                    m_ptr  = (g + 1) % NR;
                end
            end else if (!req_valid[g]) begin
                m_run++;
                if (m_run == TO) begin
                    m_send  = 1'b0;
                    m_ptr   = (g + 1) % NR;
                    m_abort = 1'b1;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (pending() && guard < 20000) begin
            step();
            guard++;
        end
        chk(tag, 32'(pending()), 32'd0);
        step();
        step();
    endtask

    initial begin
        int  len;
        bit  saw_abort;
        bit  lost_busy;
        int  guard;

        rst_n            = 1'b0;
        clear_drivers();
        nt_req_data      = {(NR*WL){1'b0}};
        nt_req_valid     = {NR{1'b0}};
        nt_req_last      = {NR{1'b0}};
        nt_tx_data_ready = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_valid", 32'(tx_data_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesters busy with single-word packets, uart_tx always ready.
        rdy_max = 0;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < NR; r++) add_word(r, 8'($urandom), 1'b1, 0);
        end
        grant_log.delete();
        drain("rr_drain");
        chk("rr_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < grant_log.size()) chk($sformatf("rr_order%0d", k), 32'(grant_log[k]), 32'(k % NR));
        end

        // Requester 3 stalls mid-packet; requester 0 waits and must win after the abort.
        grant_log.delete();
        abort_seen = 0;
        add_word(3, 8'h33, 1'b0, 0);
        add_word(0, 8'hA0, 1'b1, 5);
        drain("stall_drain");
        chk("stall_aborts", 32'(abort_seen), 32'd1);
        chk("stall_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("stall_first", 32'(grant_log[0]), 32'd3);
            chk("stall_next", 32'(grant_log[1]), 32'd0);
        end

        // Random multi-word packets, random pacing and occasional stalls long enough to abort.
        rdy_max = 4;
        for (int r = 0; r < NR; r++) begin
            for (int p = 0; p < 6; p++) begin
                len = $urandom_range(4, 1);
                for (int w = 0; w < len; w++) begin
                    add_word(r, 8'($urandom), (w == len - 1),
                             (w == 0) ? $urandom_range(6, 0) :
                             (($urandom_range(9, 0) == 0) ? $urandom_range(24, 10) : $urandom_range(3, 0)));
                end
            end
        end
        drain("rand_drain");

        // Asynchronous reset between clock edges while requester 2 is mid-packet.
        for (int w = 0; w < 5; w++) add_word(2, 8'h40 + 8'(w), (w == 4), 0);
        guard = 0;
        while (!m_send && guard < 20) begin
            step();
            guard++;
        end
        chk("pre_rst_granted", 32'(m_send), 32'd1);
        @(posedge clk);
        #3;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tx_valid", 32'(tx_data_valid), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_tx_data", 32'(tx_data), 32'd0);
        chk("arst_grant", 32'(grant_id), 32'd0);
        repeat (2) @(posedge clk);
        clear_drivers();
        m_send  = 1'b0;
        m_gid   = 0;
        m_ptr   = 0;
        m_run   = 0;
        m_abort = 1'b0;
        grant_log.delete();
        add_word(3, 8'hC3, 1'b1, 0);
        add_word(1, 8'hC1, 1'b1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drain("post_rst_drain");
        if (grant_log.size() == 2) begin
            chk("post_rst_first", 32'(grant_log[0]), 32'd1);
            chk("post_rst_second", 32'(grant_log[1]), 32'd3);
        end else begin
            chk("post_rst_count", 32'(grant_log.size()), 32'd2);
        end

        // Timeout disabled: a 10000-cycle stall must not cost the grant.
        @(negedge clk);
        nt_req_valid     = 4'b0010;
        nt_req_last      = 4'b0000;
        nt_req_data      = {8'h00, 8'h00, 8'h55, 8'h00};
        nt_tx_data_ready = 1'b1;
        @(negedge clk);
        chk("nt_busy", 32'(nt_busy), 32'd1);
        chk("nt_grant", 32'(nt_grant_id), 32'd1);
        chk("nt_tx_data", 32'(nt_tx_data), 32'h55);
        chk("nt_req_ready", 32'(nt_req_ready), 32'h2);
        @(negedge clk);
        nt_req_valid = 4'b0000;
        saw_abort = 1'b0;
        lost_busy = 1'b0;
        repeat (10000) begin
            @(negedge clk);
            saw_abort = saw_abort | nt_abort;
            lost_busy = lost_busy | ~nt_busy;
        end
        chk("nt_no_abort", 32'(saw_abort), 32'd0);
        chk("nt_busy_held", 32'(lost_busy), 32'd0);
        chk("nt_grant_held", 32'(nt_grant_id), 32'd1);
        nt_req_valid = 4'b0010;
        nt_req_last  = 4'b0010;
        nt_req_data  = {8'h00, 8'h00, 8'h66, 8'h00};
        #1;
        chk("nt_resume_valid", 32'(nt_tx_data_valid), 32'd1);
        chk("nt_resume_data", 32'(nt_tx_data), 32'h66);
        @(negedge clk);
        nt_req_valid = 4'b0000;
        nt_req_last  = 4'b0000;
        #1;
        chk("nt_done_busy", 32'(nt_busy), 32'd0);
        chk("nt_done_grant", 32'(nt_grant_id), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
